// File: rtl/stack_cpu_pkg.sv
// Shared encodings for the stack CPU: opcodes, ALU sub-ops, jump conditions, FSM states.
// Build option STACK_CPU_TRAP_EN adds the TRAP state for stack overflow/underflow faults.
package stack_cpu_pkg;

    typedef enum logic [1:0] {
        OP_LIT  = 2'b00,
        OP_ALU  = 2'b01,
        OP_JMP  = 2'b10,
        OP_HALT = 2'b11
    } opcode_t;

    // Sub-ops 10..15 are deliberately unassigned and execute as no-ops.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOT  = 4'd5,
        ALU_DUP  = 4'd6,
        ALU_DROP = 4'd7,
        ALU_SWAP = 4'd8,
        ALU_ADC  = 4'd9
    } alu_op_t;

    typedef enum logic [2:0] {
        JC_ALWAYS = 3'd0,
        JC_ZERO   = 3'd1,
        JC_NZ     = 3'd2,
        JC_NEG    = 3'd3,
        JC_CARRY  = 3'd4,
        JC_NEVER5 = 3'd5,
        JC_NEVER6 = 3'd6,
        JC_NEVER7 = 3'd7
    } jmp_cond_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
`ifdef STACK_CPU_TRAP_EN
        ST_HALT  = 2'd2,
        ST_TRAP  = 2'd3
`else
        ST_HALT  = 2'd2
`endif
    } state_t;

endpackage

// File: rtl/stack_cpu_alu.sv
// Combinational ALU: arithmetic/logic on TOS and NOS; carry passes through for non-arithmetic ops.
module stack_cpu_alu
    import stack_cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] tos,
    input  logic [DATA_W-1:0] nos,
    input  logic              carry_in,
    input  logic [3:0]        sub_op,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide      = '0;
        result    = tos;
        carry_out = carry_in;
        case (sub_op)
            ALU_ADD: begin
                wide      = {1'b0, nos} + {1'b0, tos};
                result    = wide[DATA_W-1:0];
                carry_out = wide[DATA_W];
            end
            // Top bit of the widened difference is the borrow (NOS < TOS).
            ALU_SUB: begin
                wide      = {1'b0, nos} - {1'b0, tos};
                result    = wide[DATA_W-1:0];
                carry_out = wide[DATA_W];
            end
            ALU_ADC: begin
                wide      = {1'b0, nos} + {1'b0, tos} + {{DATA_W{1'b0}}, carry_in};
                result    = wide[DATA_W-1:0];
                carry_out = wide[DATA_W];
            end
            ALU_AND: result = nos & tos;
            ALU_OR:  result = nos | tos;
            ALU_XOR: result = nos ^ tos;
            ALU_NOT: result = ~tos;
            default: ;
        endcase
    end

endmodule

// File: rtl/stack_cpu.sv
// Stack CPU top: fetch/execute FSM, stack storage and program counter.
// Define STACK_CPU_TRAP_EN to trap on stack faults; otherwise the stack pointer wraps silently.
module stack_cpu
    import stack_cpu_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 16
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    output logic                         o_imem_req,
    output logic [ADDR_W-1:0]            o_imem_addr,
    input  logic                         i_imem_ack,
    input  logic [DATA_W+1:0]            i_imem_data,
    output logic [ADDR_W-1:0]            o_pc,
    output logic [DATA_W-1:0]            o_tos,
    output logic [$clog2(STACK_DEPTH):0] o_depth,
    output logic                         o_carry,
    output logic                         o_halted,
    output logic                         o_trap
);

    localparam int SP_W = $clog2(STACK_DEPTH);
    localparam logic [SP_W:0] DEPTH_FULL = (SP_W+1)'(STACK_DEPTH);

    if (ADDR_W > DATA_W - 3) begin : g_bad_addr_w
        $error("stack_cpu: ADDR_W must not exceed DATA_W-3");
    end
    if ((STACK_DEPTH < 4) || ((STACK_DEPTH & (STACK_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("stack_cpu: STACK_DEPTH must be a power of two and at least 4");
    end

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   pc_reg, pc_next;
    logic [DATA_W+1:0]   instr_reg;
    logic [SP_W-1:0]     sp_reg, sp_next, base_idx, base_hi_idx;
    logic [SP_W:0]       depth_reg, depth_next;
    logic                carry_reg;
    logic                req_en_reg;
    logic [DATA_W-1:0]   stack_mem [STACK_DEPTH];

    logic [1:0]          opcode_sel;
    logic [3:0]          alu_sel;
    logic [2:0]          cond_sel;
    logic [DATA_W-1:0]   tos_val, nos_val, alu_result, push_lo, push_hi;
    logic                alu_carry, taken, upd_carry, commit, fetch_ack;
    logic [1:0]          n_pop, n_push;
    logic signed [SP_W+2:0] depth_calc;

    assign opcode_sel = instr_reg[DATA_W+1:DATA_W];
    assign alu_sel    = instr_reg[3:0];
    assign cond_sel   = instr_reg[DATA_W-1:DATA_W-3];
    assign fetch_ack  = (state_reg == ST_FETCH) && req_en_reg && i_imem_ack;

    // Entries not currently held read as zero so an empty stack never exposes stale data.
    assign tos_val = (depth_reg != '0) ? stack_mem[sp_reg - SP_W'(1)] : '0;
    assign nos_val = (depth_reg > (SP_W+1)'(1)) ? stack_mem[sp_reg - SP_W'(2)] : '0;

    stack_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .tos       (tos_val),
        .nos       (nos_val),
        .carry_in  (carry_reg),
        .sub_op    (alu_sel),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    // Every instruction is described as "pop n_pop, then push n_push words (push_lo first)".
    always_comb begin
        n_pop     = 2'd0;
        n_push    = 2'd0;
        push_lo   = tos_val;
        push_hi   = tos_val;
        taken     = 1'b0;
        upd_carry = 1'b0;
        case (opcode_sel)
            OP_LIT: begin
                n_push  = 2'd1;
                push_lo = instr_reg[DATA_W-1:0];
            end
            OP_ALU: begin
                case (alu_sel)
                    ALU_ADD, ALU_SUB, ALU_ADC: begin
                        n_pop = 2'd2; n_push = 2'd1; push_lo = alu_result; upd_carry = 1'b1;
                    end
                    ALU_AND, ALU_OR, ALU_XOR: begin
                        n_pop = 2'd2; n_push = 2'd1; push_lo = alu_result;
                    end
                    ALU_NOT:  begin n_pop = 2'd1; n_push = 2'd1; push_lo = alu_result; end
                    ALU_DUP:  begin n_pop = 2'd1; n_push = 2'd2; end
                    ALU_DROP: n_pop = 2'd1;
                    ALU_SWAP: begin
                        n_pop = 2'd2; n_push = 2'd2; push_lo = tos_val; push_hi = nos_val;
                    end
                    default: ;
                endcase
            end
            OP_JMP: begin
                case (cond_sel)
                    JC_ALWAYS: taken = 1'b1;
                    JC_ZERO:   begin n_pop = 2'd1; taken = (tos_val == '0); end
                    JC_NZ:     begin n_pop = 2'd1; taken = (tos_val != '0); end
                    JC_NEG:    begin n_pop = 2'd1; taken = tos_val[DATA_W-1]; end
                    JC_CARRY:  taken = carry_reg;
                    default:   ;
                endcase
            end
            default: ;
        endcase
    end

    assign base_idx    = sp_reg - SP_W'(n_pop);
    assign base_hi_idx = base_idx + SP_W'(1);
    assign sp_next     = base_idx + SP_W'(n_push);

    always_comb begin
        depth_calc = $signed({2'b00, depth_reg})
                   - $signed({{(SP_W+1){1'b0}}, n_pop})
                   + $signed({{(SP_W+1){1'b0}}, n_push});
        if (depth_calc < 0)
            depth_next = '0;
        else if (depth_calc > $signed({2'b00, DEPTH_FULL}))
            depth_next = DEPTH_FULL;
        else
            depth_next = depth_calc[SP_W:0];
    end

`ifdef STACK_CPU_TRAP_EN
    logic underflow, overflow, fault;
    assign underflow = ({{(SP_W-1){1'b0}}, n_pop} > depth_reg);
    assign overflow  = (n_push > n_pop) && (depth_reg == DEPTH_FULL);
    assign fault     = underflow || overflow;
`endif

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        commit     = 1'b0;
        case (state_reg)
            ST_FETCH: if (fetch_ack) state_next = ST_EXEC;
            ST_EXEC: begin
`ifdef STACK_CPU_TRAP_EN
                if (fault)
                    state_next = ST_TRAP;
                else
`endif
                if (opcode_sel == OP_HALT) begin
                    state_next = ST_HALT;
                end else begin
                    commit     = 1'b1;
                    pc_next    = taken ? instr_reg[ADDR_W-1:0] : pc_reg + ADDR_W'(1);
                    state_next = ST_FETCH;
                end
            end
            default: ;
        endcase
    end

    // req_en_reg keeps the request low for the cycle following reset and masks stale acks.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg  <= ST_FETCH;
            pc_reg     <= '0;
            sp_reg     <= '0;
            depth_reg  <= '0;
            carry_reg  <= 1'b0;
            req_en_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            req_en_reg <= 1'b1;
            if (commit) begin
                sp_reg    <= sp_next;
                depth_reg <= depth_next;
                if (upd_carry) carry_reg <= alu_carry;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset && fetch_ack) instr_reg <= i_imem_data;
        if (!i_reset && commit) begin
            if (n_push != 2'd0) stack_mem[base_idx]    <= push_lo;
            if (n_push == 2'd2) stack_mem[base_hi_idx] <= push_hi;
        end
    end

    assign o_imem_req  = (state_reg == ST_FETCH) && req_en_reg;
    assign o_imem_addr = pc_reg;
    assign o_pc        = pc_reg;
    assign o_tos       = tos_val;
    assign o_depth     = depth_reg;
    assign o_carry     = carry_reg;
    assign o_halted    = (state_reg == ST_HALT);
`ifdef STACK_CPU_TRAP_EN
    assign o_trap      = (state_reg == ST_TRAP);
`else
    assign o_trap      = 1'b0;
`endif

endmodule

// File: tb/tb_stack_cpu.sv
// Bench for stack_cpu: table of small programs with hand-computed final state, plus reset/ack sequences.
// Expectations for stack faults follow STACK_CPU_TRAP_EN.
module tb_stack_cpu;

    localparam int NV = 11;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [17:0] imem_data;
    logic [11:0] pc;
    logic [15:0] tos;
    logic [4:0]  depth;
    logic        carry, halted, trap;

    logic        auto_resp, resp_ack, man_ack;
    logic [17:0] resp_data, man_data;
    int unsigned cur_delay;
    logic [17:0] rom [64];
    int          total, bad;

    typedef struct {
        int unsigned delay;
        logic [15:0] tos;
        logic [4:0]  depth;
        logic        carry;
        logic [11:0] pc;
        logic        halted;
        logic        trap;
    } vec_t;

    vec_t        vecs [NV];
    logic [17:0] prog [NV][64];

    assign imem_ack  = auto_resp ? resp_ack  : man_ack;
    assign imem_data = auto_resp ? resp_data : man_data;

    stack_cpu dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .o_imem_req  (imem_req),
        .o_imem_addr (imem_addr),
        .i_imem_ack  (imem_ack),
        .i_imem_data (imem_data),
        .o_pc        (pc),
        .o_tos       (tos),
        .o_depth     (depth),
        .o_carry     (carry),
        .o_halted    (halted),
        .o_trap      (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] lit(input logic [15:0] v);
        return {2'b00, v};
    endfunction
    function automatic logic [17:0] alu(input logic [3:0] op);
        return {2'b01, 12'h000, op};
    endfunction
    function automatic logic [17:0] jmp(input logic [2:0] c, input logic [11:0] t);
        return {2'b10, c, 1'b0, t};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, exp);
        end
    endtask

    task automatic set_vec(input int v, input int unsigned d, input logic [15:0] t, input logic [4:0] dp,
                           input logic c, input logic [11:0] p, input logic h, input logic tr);
        vecs[v].delay = d; vecs[v].tos = t; vecs[v].depth = dp; vecs[v].carry = c;
        vecs[v].pc = p; vecs[v].halted = h; vecs[v].trap = tr;
    endtask

    // Instruction memory responder: acks after cur_delay waiting cycles, checks address stability.
    initial begin
        logic [11:0] held_addr;
        logic        have_addr;
        int unsigned wait_cnt;
        resp_ack = 1'b0; resp_data = '0; have_addr = 1'b0; wait_cnt = 0; held_addr = '0;
        forever begin
            @(negedge clk);
            if (auto_resp && imem_req && !resp_ack) begin
                if (have_addr) check("addr_stable", {20'h0, imem_addr}, {20'h0, held_addr});
                held_addr = imem_addr;
                have_addr = 1'b1;
                if (wait_cnt >= cur_delay) begin
                    resp_ack  = 1'b1;
                    resp_data = rom[imem_addr[5:0]];
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                resp_ack  = 1'b0;
                have_addr = 1'b0;
                wait_cnt  = 0;
            end
        end
    end

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; auto_resp = 1'b1; man_ack = 1'b0; man_data = '0; cur_delay = 0;

        for (int v = 0; v < NV; v++)
            for (int a = 0; a < 64; a++)
                prog[v][a] = {2'b11, 16'h0000};

        // 0/1: 3+5 with immediate and delayed acks
        for (int v = 0; v < 2; v++) begin
            prog[v][0] = lit(16'd3); prog[v][1] = lit(16'd5); prog[v][2] = alu(4'd0);
        end
        set_vec(0, 0, 16'd8, 5'd1, 1'b0, 12'h003, 1'b1, 1'b0);
        set_vec(1, 4, 16'd8, 5'd1, 1'b0, 12'h003, 1'b1, 1'b0);
        // 2: carry out then jump on carry
        prog[2][0] = lit(16'hFFFF); prog[2][1] = lit(16'd1); prog[2][2] = alu(4'd0);
        prog[2][3] = lit(16'd0);    prog[2][4] = jmp(3'd4, 12'h010);
        set_vec(2, 0, 16'h0000, 5'd2, 1'b1, 12'h010, 1'b1, 1'b0);
        // 3: jump-if-zero taken, then not taken (both pop)
        prog[3][0] = lit(16'd0); prog[3][1] = jmp(3'd1, 12'h020);
        prog[3][32] = lit(16'd7); prog[3][33] = jmp(3'd1, 12'h030);
        set_vec(3, 0, 16'h0000, 5'd0, 1'b0, 12'h022, 1'b1, 1'b0);
        // 4: seventeen pushes on a 16-deep stack
        for (int a = 0; a < 17; a++) prog[4][a] = lit(16'(a + 1));
        // 5: ADD on an empty stack
        prog[5][0] = alu(4'd0);
`ifdef STACK_CPU_TRAP_EN
        set_vec(4, 0, 16'd16, 5'd16, 1'b0, 12'd16, 1'b0, 1'b1);
        set_vec(5, 0, 16'd0,  5'd0,  1'b0, 12'd0,  1'b0, 1'b1);
`else
        set_vec(4, 0, 16'd17, 5'd16, 1'b0, 12'd17, 1'b1, 1'b0);
        set_vec(5, 0, 16'd0,  5'd0,  1'b0, 12'd1,  1'b1, 1'b0);
`endif
        // 6: SUB with borrow (3 - 5)
        prog[6][0] = lit(16'd3); prog[6][1] = lit(16'd5); prog[6][2] = alu(4'd1);
        set_vec(6, 0, 16'hFFFE, 5'd1, 1'b1, 12'h003, 1'b1, 1'b0);
        // 7: logic ops chain
        prog[7][0] = lit(16'h0F0F); prog[7][1] = lit(16'h00FF); prog[7][2] = alu(4'd2);
        prog[7][3] = lit(16'hF000); prog[7][4] = alu(4'd3);     prog[7][5] = lit(16'h00FF);
        prog[7][6] = alu(4'd4);     prog[7][7] = alu(4'd5);
        set_vec(7, 0, 16'h0F0F, 5'd1, 1'b0, 12'h008, 1'b1, 1'b0);
        // 8: SWAP, DUP, DROP then SUB reveals ordering
        prog[8][0] = lit(16'd1); prog[8][1] = lit(16'd2); prog[8][2] = alu(4'd8);
        prog[8][3] = alu(4'd6);  prog[8][4] = alu(4'd7);  prog[8][5] = alu(4'd1);
        set_vec(8, 2, 16'd1, 5'd1, 1'b0, 12'h006, 1'b1, 1'b0);
        // 9: ADD sets carry, ADC consumes it
        prog[9][0] = lit(16'hFFFF); prog[9][1] = lit(16'd2); prog[9][2] = alu(4'd0);
        prog[9][3] = lit(16'd5);    prog[9][4] = alu(4'd9);
        set_vec(9, 0, 16'd7, 5'd1, 1'b0, 12'h005, 1'b1, 1'b0);
        // 10: no-op sub-op, never-jump, NZ taken, MSB not taken then taken
        prog[10][0] = lit(16'd4);    prog[10][1] = alu(4'd12);
        prog[10][2] = jmp(3'd5, 12'h030); prog[10][3] = jmp(3'd2, 12'h010);
        prog[10][16] = lit(16'd9);   prog[10][17] = jmp(3'd3, 12'h018);
        prog[10][18] = lit(16'h8000); prog[10][19] = jmp(3'd3, 12'h020);
        prog[10][32] = lit(16'd6);
        set_vec(10, 1, 16'd6, 5'd1, 1'b0, 12'h021, 1'b1, 1'b0);

        for (int v = 0; v < NV; v++) begin
            logic done;
            for (int a = 0; a < 64; a++) rom[a] = prog[v][a];
            cur_delay = vecs[v].delay;
            rst = 1'b1;
            @(posedge clk); @(posedge clk); #1;
            rst = 1'b0;
            done = 1'b0;
            for (int c = 0; c < 2000; c++) begin
                @(posedge clk); #1;
                if (halted || trap) begin
                    done = 1'b1;
                    break;
                end
            end
            check($sformatf("v%0d finished", v), {31'h0, done},   32'd1);
            check($sformatf("v%0d tos", v),      {16'h0, tos},    {16'h0, vecs[v].tos});
            check($sformatf("v%0d depth", v),    {27'h0, depth},  {27'h0, vecs[v].depth});
            check($sformatf("v%0d carry", v),    {31'h0, carry},  {31'h0, vecs[v].carry});
            check($sformatf("v%0d pc", v),       {20'h0, pc},     {20'h0, vecs[v].pc});
            check($sformatf("v%0d halted", v),   {31'h0, halted}, {31'h0, vecs[v].halted});
            check($sformatf("v%0d trap", v),     {31'h0, trap},   {31'h0, vecs[v].trap});
            $display("vec %0d: pc=%03h tos=%04h depth=%0d carry=%0b halted=%0b trap=%0b bad_so_far=%0d",
                     v, pc, tos, depth, carry, halted, trap, bad);
        end

        // Hand-driven fetch handshake, ack outside FETCH, and reset during a fetch.
        auto_resp = 1'b0;
        man_ack = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst req",    {31'h0, imem_req}, 32'd0);
        check("rst pc",     {20'h0, pc},       32'd0);
        check("rst depth",  {27'h0, depth},    32'd0);
        check("rst tos",    {16'h0, tos},      32'd0);
        check("rst carry",  {31'h0, carry},    32'd0);
        check("rst halted", {31'h0, halted},   32'd0);
        check("rst trap",   {31'h0, trap},     32'd0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("wait%0d req", c),  {31'h0, imem_req},  32'd1);
            check($sformatf("wait%0d addr", c), {20'h0, imem_addr}, 32'd0);
        end
        man_ack = 1'b1; man_data = lit(16'h1234);
        @(posedge clk); #1;
        check("exec req", {31'h0, imem_req}, 32'd0);
        man_data = lit(16'h5555);
        @(posedge clk); #1;
        check("lit tos",   {16'h0, tos},      32'h1234);
        check("lit depth", {27'h0, depth},    32'd1);
        check("lit pc",    {20'h0, pc},       32'd1);
        check("lit req",   {31'h0, imem_req}, 32'd1);
        $display("manual fetch: tos=%04h depth=%0d pc=%03h", tos, depth, pc);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst pc",    {20'h0, pc},       32'd0);
        check("midrst depth", {27'h0, depth},    32'd0);
        check("midrst req",   {31'h0, imem_req}, 32'd0);
        rst = 1'b0; man_ack = 1'b0;
        @(posedge clk); #1;
        check("refetch req",  {31'h0, imem_req},  32'd1);
        check("refetch addr", {20'h0, imem_addr}, 32'd0);
        check("refetch depth", {27'h0, depth},    32'd0);
        $display("reset mid-fetch: pc=%03h depth=%0d req=%0b", pc, depth, imem_req);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
